radio_seq_ctrl: RTL
===================

Name: radio_seq_ctrl

Overview:
- Per-radio power/receive sequencer for the timing engine.
- Drives the radio enable and rx-enable buses that feed the per-bit radio output registers (BIT_WIDTH channels).
- Each channel steps OFF -> WAIT -> WARM -> RX -> COOL -> OFF.
- A single shared warm-up engine (synthesiser settling) is granted round-robin, so at most one radio warms up at a time.

Parameters:
- BIT_WIDTH, 2, number of radio channels (>=1).
- CNT_W, 8, width of the warm-up and cool-down cycle counts.

Ports:
- ck  input  1  clock.
- arst_n  input  1  asynchronous reset, active-low.
- isolate  input  1  synchronous force-off of all channels.
- cfg_warmup  input  CNT_W  warm-up length; WARM lasts cfg_warmup+1 cycles.
- cfg_cooldown  input  CNT_W  cool-down length; COOL lasts cfg_cooldown+1 cycles.
- rx_req  input  BIT_WIDTH  per-channel level request for receive.
- radio_enable  output  BIT_WIDTH  radio powered: high in WARM, RX, COOL.
- radio_rx_en  output  BIT_WIDTH  receive enabled: high only in RX.
- warm_busy  output  1  shared warm-up engine owned by some channel.
- warm_owner  output  max(1,$clog2(BIT_WIDTH))  index of the current WARM channel; 0 when idle.

Behaviour:
- Reset (arst_n low, asynchronous):
  - all channels OFF; all counters 0.
  - round-robin pointer 0.
  - radio_enable=0, radio_rx_en=0, warm_busy=0, warm_owner=0.
- All outputs are flop-driven.
  - They change on the same edge the state changes.
  - They have no combinational path from any input.
- Channel FSM, evaluated every ck edge while isolate=0:
  - OFF: rx_req[i]=1 -> WAIT.
  - WAIT:
    - rx_req[i]=0 -> OFF (request withdrawn, no grant consumed).
    - granted -> WARM. The shared counter loads cfg_warmup on the grant edge.
  - WARM:
    - rx_req[i]=0 -> COOL; engine released; cool counter loads cfg_cooldown.
    - else counter==0 -> RX.
    - else counter decrements.
  - RX: rx_req[i]=0 -> COOL; per-channel cool counter loads cfg_cooldown.
  - COOL:
    - counter==0 -> OFF, else decrement.
    - rx_req is ignored in COOL.
    - A held request re-enters WAIT the cycle after OFF.
- Arbiter:
  - A grant is issued only on an edge where no channel is in WARM at the start of the cycle.
  - A WARM exit and a new grant therefore cannot coincide; there is a minimum one-cycle gap.
  - Candidates are the channels in WAIT with rx_req still high.
  - The first candidate at or after the pointer (modulo BIT_WIDTH) wins.
  - The pointer then becomes winner+1 mod BIT_WIDTH.
  - The pointer is unchanged when there is no grant.
- Config sampling: cfg_warmup and cfg_cooldown are sampled only at counter load. Changes mid-count have no effect.
- Latency with the engine free and rx_req rising before edge k:
  - WAIT at k.
  - WARM at k+1.
  - RX (radio_rx_en=1) at k+2+cfg_warmup.
- rx_req dropping in RX: radio_rx_en falls next edge; radio_enable falls cfg_cooldown+1 edges later.
- isolate=1 (synchronous, highest priority after reset):
  - On the next edge every channel goes OFF, counters clear, warm engine released, pointer resets to 0.
  - All outputs are 0 from that edge.
  - While isolate is held, no channel leaves OFF.
  - On deassertion, normal operation resumes from OFF.
- arst_n asserted mid-sequence clears immediately regardless of state.
- Counter width: CNT_W bits, no wrap. Decrement never occurs at 0.

Test Plan:
- Single channel: cfg_warmup=3, cfg_cooldown=2, rx_req[0] rises before edge 0.
  - Required: WAIT@0, radio_enable[0]=1@1, radio_rx_en[0]=1@5.
  - Then rx_req[0]=0 before edge 10: rx_en=0@10, enable=0@13.
- Contention: both rx_req rise together, cfg_warmup=1, pointer 0.
  - Required: ch0 WARM@1, RX@3.
  - warm_busy=0 for one cycle, ch1 WARM@4, RX@6.
  - Pointer=0 after the ch1 grant.
- Round-robin fairness: BIT_WIDTH=4, all channels request repeatedly with short RX.
  - Required: grant order 0,1,2,3,0,…; no channel granted twice before the others.
- Abort during WARM: cfg_warmup=10, drop rx_req[0] at WARM cycle 4.
  - Required: radio_rx_en never 1; COOL for cfg_cooldown+1 cycles; engine granted to the waiting ch1 the edge after release.
- Isolate mid-RX: both channels in RX/WARM, isolate=1 for 5 cycles.
  - Required: all outputs 0 on the next edge and held.
  - After release, with requests high: WAIT, then ch0 granted first.
- Async reset: assert arst_n low between edges during COOL.
  - Required: outputs 0 immediately, before the next ck edge.
  - Zero-length configs (cfg_warmup=0, cfg_cooldown=0): WARM and COOL each last exactly 1 cycle.

Source files
------------

// File: rtl/radio_seq_ctrl.sv
// radio_seq_ctrl: per-channel radio power/receive sequencer.
// Each channel walks OFF -> WAIT -> WARM -> RX -> COOL -> OFF. A single
// shared warm-up engine (synthesiser settling) is handed out round-robin, so
// at most one channel is ever in WARM. All outputs come straight from flops.
module radio_seq_ctrl #(
  parameter int unsigned BIT_WIDTH = 2,
  parameter int unsigned CNT_W     = 8,
  localparam int unsigned OW       = (BIT_WIDTH > 1) ? $clog2(BIT_WIDTH) : 1
) (
  input  logic                 ck,
  input  logic                 arst_n,
  input  logic                 isolate,
  input  logic [CNT_W-1:0]     cfg_warmup,
  input  logic [CNT_W-1:0]     cfg_cooldown,
  input  logic [BIT_WIDTH-1:0] rx_req,
  output logic [BIT_WIDTH-1:0] radio_enable,
  output logic [BIT_WIDTH-1:0] radio_rx_en,
  output logic                 warm_busy,
  output logic [OW-1:0]        warm_owner
);

  typedef enum logic [2:0] {
    ST_OFF  = 3'd0,
    ST_WAIT = 3'd1,
    ST_WARM = 3'd2,
    ST_RX   = 3'd3,
    ST_COOL = 3'd4
  } state_e;

  state_e               state_q    [BIT_WIDTH];
  state_e               state_d    [BIT_WIDTH];
  logic [CNT_W-1:0]     cool_q     [BIT_WIDTH];
  logic [CNT_W-1:0]     cool_d     [BIT_WIDTH];
  logic [CNT_W-1:0]     warm_cnt_q, warm_cnt_d;
  logic [OW-1:0]        ptr_q,      ptr_d;
  logic [OW-1:0]        owner_q,    owner_d;
  logic                 busy_q,     busy_d;
  logic [BIT_WIDTH-1:0] en_q,       en_d;
  logic [BIT_WIDTH-1:0] rxen_q,     rxen_d;

  logic [BIT_WIDTH-1:0] cand_s;
  logic                 warm_active_s;
  logic                 warm_release_s;
  logic                 grant_vld_s;
  logic [OW-1:0]        grant_idx_s;

  // Grant candidates and shared-engine status, all from the current state.
  always_comb begin
    cand_s         = '0;
    warm_active_s  = 1'b0;
    warm_release_s = 1'b0;
    for (int i = 0; i < BIT_WIDTH; i++) begin
      cand_s[i]      = (state_q[i] == ST_WAIT) && rx_req[i];
      warm_active_s  = warm_active_s | (state_q[i] == ST_WARM);
      // The engine frees up when its owner aborts or finishes settling.
      warm_release_s = warm_release_s |
                       ((state_q[i] == ST_WARM) & (~rx_req[i] | (warm_cnt_q == '0)));
    end
  end

  // Round-robin arbiter: first candidate at or after the pointer, wrapping.
  // No grant while any channel is in WARM, which forces a one-cycle gap.
  always_comb begin
    grant_vld_s = 1'b0;
    grant_idx_s = '0;
    for (int i = 0; i < BIT_WIDTH; i++) begin
      if (!grant_vld_s && !warm_active_s && cand_s[i] && (i >= int'(ptr_q))) begin
        grant_vld_s = 1'b1;
        grant_idx_s = OW'(i);
      end else begin
        // keep earlier winner
      end
    end
    for (int i = 0; i < BIT_WIDTH; i++) begin
      if (!grant_vld_s && !warm_active_s && cand_s[i]) begin
        grant_vld_s = 1'b1;
        grant_idx_s = OW'(i);
      end else begin
        // keep earlier winner
      end
    end
  end

  // Channel next-state, counters and pointer; isolate overrides everything.
  always_comb begin
    warm_cnt_d = warm_cnt_q;
    ptr_d      = ptr_q;
    owner_d    = owner_q;
    for (int i = 0; i < BIT_WIDTH; i++) begin
      state_d[i] = state_q[i];
      cool_d[i]  = cool_q[i];
    end

    if (isolate) begin
      warm_cnt_d = '0;
      ptr_d      = '0;
      owner_d    = '0;
      for (int i = 0; i < BIT_WIDTH; i++) begin
        state_d[i] = ST_OFF;
        cool_d[i]  = '0;
      end
    end else begin
      for (int i = 0; i < BIT_WIDTH; i++) begin
        case (state_q[i])
          ST_OFF: begin
            if (rx_req[i]) begin
              state_d[i] = ST_WAIT;
            end else begin
              state_d[i] = ST_OFF;
            end
          end
          ST_WAIT: begin
            if (!rx_req[i]) begin
              state_d[i] = ST_OFF;
            end else if (grant_vld_s && (grant_idx_s == OW'(i))) begin
              state_d[i] = ST_WARM;
            end else begin
              state_d[i] = ST_WAIT;
            end
          end
          ST_WARM: begin
            if (!rx_req[i]) begin
              state_d[i] = ST_COOL;
              cool_d[i]  = cfg_cooldown;
            end else if (warm_cnt_q == '0) begin
              state_d[i] = ST_RX;
            end else begin
              state_d[i] = ST_WARM;
            end
          end
          ST_RX: begin
            if (!rx_req[i]) begin
              state_d[i] = ST_COOL;
              cool_d[i]  = cfg_cooldown;
            end else begin
              state_d[i] = ST_RX;
            end
          end
          ST_COOL: begin
            // Requests are ignored until the channel is fully off.
            if (cool_q[i] == '0) begin
              state_d[i] = ST_OFF;
            end else begin
              cool_d[i]  = cool_q[i] - CNT_W'(1);
            end
          end
          default: begin
            state_d[i] = ST_OFF;
            cool_d[i]  = '0;
          end
        endcase
      end

      // Shared warm counter: load on grant, clear on release, else count down.
      if (grant_vld_s) begin
        warm_cnt_d = cfg_warmup;
      end else if (warm_release_s) begin
        warm_cnt_d = '0;
      end else if (warm_active_s) begin
        warm_cnt_d = warm_cnt_q - CNT_W'(1);
      end else begin
        warm_cnt_d = warm_cnt_q;
      end

      if (grant_vld_s) begin
        owner_d = grant_idx_s;
        if (grant_idx_s == OW'(BIT_WIDTH - 1)) begin
          ptr_d = '0;
        end else begin
          ptr_d = grant_idx_s + OW'(1);
        end
      end else if (warm_active_s && !warm_release_s) begin
        owner_d = owner_q;
      end else begin
        owner_d = '0;
      end
    end
  end

  // Output values derived from the next state so they move with the state.
  always_comb begin
    en_d   = '0;
    rxen_d = '0;
    busy_d = 1'b0;
    for (int i = 0; i < BIT_WIDTH; i++) begin
      en_d[i]   = (state_d[i] == ST_WARM) || (state_d[i] == ST_RX) ||
                  (state_d[i] == ST_COOL);
      rxen_d[i] = (state_d[i] == ST_RX);
      busy_d    = busy_d | (state_d[i] == ST_WARM);
    end
  end

  // State, counter and output registers with asynchronous clear.
  always_ff @(posedge ck or negedge arst_n) begin
    if (!arst_n) begin
      for (int i = 0; i < BIT_WIDTH; i++) begin
        state_q[i] <= ST_OFF;
        cool_q[i]  <= '0;
      end
      warm_cnt_q <= '0;
      ptr_q      <= '0;
      owner_q    <= '0;
      busy_q     <= 1'b0;
      en_q       <= '0;
      rxen_q     <= '0;
    end else begin
      for (int i = 0; i < BIT_WIDTH; i++) begin
        state_q[i] <= state_d[i];
        cool_q[i]  <= cool_d[i];
      end
      warm_cnt_q <= warm_cnt_d;
      ptr_q      <= ptr_d;
      owner_q    <= owner_d;
      busy_q     <= busy_d;
      en_q       <= en_d;
      rxen_q     <= rxen_d;
    end
  end

  assign radio_enable = en_q;
  assign radio_rx_en  = rxen_q;
  assign warm_busy    = busy_q;
  assign warm_owner   = owner_q;

endmodule
